// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core.
// Optional lap/freeze feature is enabled by defining STOPWATCH_LAP_EN.
package stopwatch_pkg;

   localparam int BCD_W         = 4;
   localparam int DIG_MAX       = 9;
   localparam int SEC_T_MAX_DEF = 5;
   localparam int NUM_DIGITS    = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } sw_state_e;

   // Clock cycles per count tick; callers guarantee an integer ratio >= 2.
   function automatic int calc_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control/display bundle between the stopwatch core and its environment.
// The lap pulse is only present when STOPWATCH_LAP_EN is defined.
interface stopwatch_counter_if;
   import stopwatch_pkg::*;

   logic             start_stop;
   logic             clear;
`ifdef STOPWATCH_LAP_EN
   logic             lap;
`endif
   logic [BCD_W-1:0] dig0;
   logic [BCD_W-1:0] dig1;
   logic [BCD_W-1:0] dig2;
   logic [BCD_W-1:0] dig3;
   logic             running;
   logic             wrap;

`ifdef STOPWATCH_LAP_EN
   modport master (
      output start_stop, clear, lap,
      input  dig0, dig1, dig2, dig3, running, wrap
   );
   modport slave (
      input  start_stop, clear, lap,
      output dig0, dig1, dig2, dig3, running, wrap
   );
`else
   modport master (
      output start_stop, clear,
      input  dig0, dig1, dig2, dig3, running, wrap
   );
   modport slave (
      input  start_stop, clear,
      output dig0, dig1, dig2, dig3, running, wrap
   );
`endif

endinterface

// File: rtl/stopwatch_counter_bcd_digit.sv
// One BCD digit of the stopwatch: mod-(MAX+1) counter with synchronous clear
// and a combinational carry used to chain into the next more significant digit.
module bcd_digit
   import stopwatch_pkg::*;
#(
   parameter int MAX = DIG_MAX
) (
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [BCD_W-1:0] value_o,
   output logic             carry_o
);

   localparam logic [BCD_W-1:0] MAX_V = BCD_W'(MAX);

   logic [BCD_W-1:0] value_q;
   logic [BCD_W-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (clr_i) begin
         value_d = '0;
      end else if (inc_i) begin
         // >= also pulls any out-of-range value back to a legal digit
         value_d = (value_q >= MAX_V) ? '0 : value_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value_o = value_q;
   assign carry_o = inc_i && (value_q == MAX_V);

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping core: prescales clk to count ticks and counts SS.cc in BCD
// under start/stop and clear. STOPWATCH_LAP_EN adds the lap freeze of the display.
module stopwatch_counter
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ    = 1000,
   parameter int TICK_HZ   = 100,
   parameter int SEC_T_MAX = SEC_T_MAX_DEF
) (
   input  logic                 clk,
   input  logic                 sys_rst,
   stopwatch_counter_if.slave   ctrl_if
);

   localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
   localparam int PW  = $clog2(DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   sw_state_e state_q;
   sw_state_e state_d;
   logic [PW-1:0] presc_q;
   logic [PW-1:0] presc_d;
   logic          running_q;
   logic          running_d;
   logic          wrap_q;
   logic          wrap_d;
   logic          tick;

   logic [NUM_DIGITS-1:0]                inc_w;
   logic [NUM_DIGITS-1:0]                carry_w;
   logic [NUM_DIGITS-1:0][BCD_W-1:0]     live_w;
   logic [NUM_DIGITS-1:0][BCD_W-1:0]     disp_w;

   assign tick = (state_q == RUN) && (presc_q == PRESC_LAST);

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      case (state_q)
         IDLE: begin
            presc_d = '0;
            if (ctrl_if.start_stop) state_d = RUN;
         end
         RUN: begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (ctrl_if.start_stop) state_d = PAUSE;
         end
         PAUSE: begin
            if (ctrl_if.start_stop) state_d = RUN;
         end
         default: begin
            state_d = IDLE;
            presc_d = '0;
         end
      endcase
      if (ctrl_if.clear) begin
         state_d = IDLE;
         presc_d = '0;
      end
   end

   assign running_d = (state_d == RUN);
   assign wrap_d    = carry_w[NUM_DIGITS-1];

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         running_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         running_q <= running_d;
         wrap_q    <= wrap_d;
      end
   end

   // Carry ripples from hundredths up to seconds-tens; clear suppresses the tick.
   assign inc_w = {carry_w[NUM_DIGITS-2:0], tick & ~ctrl_if.clear};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         localparam int D_MAX = (gi == NUM_DIGITS - 1) ? SEC_T_MAX : DIG_MAX;
         bcd_digit #(
            .MAX (D_MAX)
         ) u_digit (
            .clk_i   (clk),
            .srst_i  (sys_rst),
            .clr_i   (ctrl_if.clear),
            .inc_i   (inc_w[gi]),
            .value_o (live_w[gi]),
            .carry_o (carry_w[gi])
         );
      end
   endgenerate

`ifdef STOPWATCH_LAP_EN
   logic                             frozen_q;
   logic                             frozen_d;
   logic [NUM_DIGITS-1:0][BCD_W-1:0] snap_q;

   always_comb begin
      frozen_d = frozen_q;
      if (ctrl_if.clear) begin
         frozen_d = 1'b0;
      end else if (ctrl_if.lap && (state_q == RUN)) begin
         frozen_d = ~frozen_q;
      end
   end

   // Snapshot is the count visible on the freezing edge.
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         frozen_q <= 1'b0;
         snap_q   <= '0;
      end else begin
         frozen_q <= frozen_d;
         if (frozen_d && !frozen_q) snap_q <= live_w;
      end
   end

   assign disp_w = frozen_q ? snap_q : live_w;
`else
   assign disp_w = live_w;
`endif

   assign ctrl_if.dig0    = disp_w[0];
   assign ctrl_if.dig1    = disp_w[1];
   assign ctrl_if.dig2    = disp_w[2];
   assign ctrl_if.dig3    = disp_w[3];
   assign ctrl_if.running = running_q;
   assign ctrl_if.wrap    = wrap_q;

endmodule
